// File: rtl/mult16_rr_sched.sv
// mult16_rr_sched: round-robin front end for one shared combinational 16x16
// multiplier. S1 registers the winning operands onto the multiplier inputs and
// S2 captures the product together with the requester ID on the response port.
module mult16_rr_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [31:0]           mul_p,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_p,
  input  logic                  rsp_ready,
  output logic [1:0]            inflight
);

  // Per-lane views of the flat operand buses.
  logic [N_REQ-1:0][15:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_p_q, rsp_p_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [1:0]       inflight_q, inflight_d;

  logic             s1_load, s2_load, accept, found;
  logic [N_REQ-1:0] win;
  logic [IDW-1:0]   win_id, idx;
  int               pos;

  // Stage advance: S2 takes S1 when the response slot is free or draining;
  // S1 reloads when empty or moving forward. Neither depends on req_ready.
  assign s2_load = s1_valid_q & (~rsp_valid_q | rsp_ready);
  assign s1_load = ~s1_valid_q | s2_load;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = IDW'(pos);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = idx;
      end
    end
  end

  assign req_ready = rst ? '0 : (s1_load ? win : '0);
  assign accept    = |req_ready;

  // Next-state for both pipeline stages, pointer and occupancy count.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (s1_load) begin
      // Operands hold when idle so the multiplier inputs do not toggle.
      s1_valid_d = accept;
      if (accept) begin
        mul_a_d = a_lane[win_id];
        mul_b_d = b_lane[win_id];
        s1_id_d = win_id;
        ptr_d   = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
      end
    end
    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_p_d     = mul_p;
      rsp_id_d    = s1_id_q;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    inflight_d = {1'b0, s1_valid_d} + {1'b0, rsp_valid_d};
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      inflight_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_mult16_rr_sched.sv
// Directed bench for mult16_rr_sched with a Booth radix-4 reference multiplier
// standing in for the shared multiplier instance.
module tb_mult16_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_p;
  logic        rsp_ready;
  logic [1:0]  inflight;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [1:0] id; logic [31:0] p; } exp_t;
  exp_t sb[$];

  mult16_rr_sched #(.N_REQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_ready(rsp_ready), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Booth radix-4 reference multiplier (signed 16x16).
  function automatic logic [31:0] booth_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] acc, ax;
    logic [16:0] yx;
    logic [2:0]  t;
    acc = '0;
    ax  = {{16{x[15]}}, x};
    yx  = {y, 1'b0};
    for (int i = 0; i < 8; i++) begin
      t = yx[2*i +: 3];
      case (t)
        3'b001, 3'b010: acc = acc + (ax << (2*i));
        3'b011:         acc = acc + (ax << (2*i+1));
        3'b100:         acc = acc - (ax << (2*i+1));
        3'b101, 3'b110: acc = acc - (ax << (2*i));
        default: ;
      endcase
    end
    return acc;
  endfunction

  always_comb mul_p = booth_mul(mul_a, mul_b);

  function automatic logic [31:0] smul(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] sx, sy, pr;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    pr = sx * sy;
    return pr;
  endfunction

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 16'(i + 5), 16'(i + 9));
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      tests++; if (inflight !== 2'd0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    end
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tests++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin fails++; $display("FAIL reset_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); end
    tests++; if (rsp_p !== 32'h0 || rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_data got=%h/%0d exp=0/0", rsp_p, rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    set_lane(1, 16'h7FFF, 16'h0002);
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b0 || inflight !== 2'd1) begin fails++; $display("FAIL single_issue got=v%b n%0d exp=v0 n1", rsp_valid, inflight); end
    tests++; if (mul_a !== 16'h7FFF || mul_b !== 16'h0002) begin fails++; $display("FAIL single_mul_ops got=%h/%h exp=7fff/0002", mul_a, mul_b); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 32'h0000FFFE) begin
      fails++; $display("FAIL single_rsp got=v%b id%0d p%h exp=v1 id1 p0000fffe", rsp_valid, rsp_id, rsp_p); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || inflight !== 2'd0) begin fails++; $display("FAIL single_done got=v%b n%0d exp=v0 n0", rsp_valid, inflight); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_p;
    int id;
    apply_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 16'(i + 1), 16'(16 + i));
    for (int c = 0; c < 8; c++) begin
      #1;
      tests++; if (req_ready !== 4'(1 << (c % 4))) begin fails++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
      @(negedge clk);
      if (c == 0) begin
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_fill got=%b exp=0", rsp_valid); end
      end else begin
        id = (c - 1) % 4;
        exp_p = 32'((id + 1) * (16 + id));
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_p !== exp_p) begin
          fails++; $display("FAIL rr_rsp[%0d] got=v%b id%0d p%h exp=v1 id%0d p%h", c, rsp_valid, rsp_id, rsp_p, id, exp_p); end
      end
    end
    req_valid = '0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== 32'd76) begin
      fails++; $display("FAIL rr_last got=v%b id%0d p%h exp=v1 id3 p%h", rsp_valid, rsp_id, rsp_p, 32'd76); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_empty got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    req_valid = 4'b0111; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_lane(i, 16'(16'h100 + i), 16'h0003);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready != 0) accepts++;
      @(negedge clk);
    end
    tests++; if (accepts !== 2) begin fails++; $display("FAIL bp_accepts got=%0d exp=2", accepts); end
    tests++; if (req_ready !== 4'b0000 || inflight !== 2'd2) begin fails++; $display("FAIL bp_full got=%b n%0d exp=0000 n2", req_ready, inflight); end
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 32'h00000300) begin
      fails++; $display("FAIL bp_hold got=v%b id%0d p%h exp=v1 id0 p00000300", rsp_valid, rsp_id, rsp_p); end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_grant got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 32'h00000303) begin
      fails++; $display("FAIL bp_drain1 got=v%b id%0d p%h exp=v1 id1 p00000303", rsp_valid, rsp_id, rsp_p); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 32'h00000306) begin
      fails++; $display("FAIL bp_drain2 got=v%b id%0d p%h exp=v1 id2 p00000306", rsp_valid, rsp_id, rsp_p); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || inflight !== 2'd0) begin fails++; $display("FAIL bp_empty got=v%b n%0d exp=v0 n0", rsp_valid, inflight); end
  endtask

  task automatic test_signed();
    exp_t e;
    int acc = 0, cyc = 0, id = 0;
    logic pend = 1'b0;
    logic [15:0] a, b;
    // ptr is 3 here, so the search order 3,0,1,2 must still find requester 2.
    req_valid = 4'b0100; rsp_ready = 1'b1;
    set_lane(2, 16'h8000, 16'hFFFF);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL signed_grant got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 32'h00008000) begin
      fails++; $display("FAIL signed_rsp got=v%b id%0d p%h exp=v1 id2 p00008000", rsp_valid, rsp_id, rsp_p); end
    // Random sweep with random backpressure; requester holds valid until granted.
    while (acc < 1000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL sweep_extra got=id%0d p%h exp=none", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_p !== e.p) begin
            fails++; $display("FAIL sweep_rsp got=id%0d p%h exp=id%0d p%h", rsp_id, rsp_p, e.id, e.p); end
        end
      end
      if (!pend) begin
        id = $urandom_range(0, 3);
        a = 16'($urandom);
        b = 16'($urandom);
        req_valid = 4'(1 << id);
        set_lane(id, a, b);
        pend = 1'b1;
      end
      #1;
      if (req_ready != 0) begin
        tests++; if (req_ready !== req_valid) begin fails++; $display("FAIL sweep_grant got=%b exp=%b", req_ready, req_valid); end
        sb.push_back('{id: 2'(id), p: smul(a, b)});
        pend = 1'b0;
        acc++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = '0; rsp_ready = 1'b1;
      if (rsp_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL sweep_extra got=id%0d p%h exp=none", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_p !== e.p) begin
            fails++; $display("FAIL sweep_rsp got=id%0d p%h exp=id%0d p%h", rsp_id, rsp_p, e.id, e.p); end
        end
      end
    end
    tests++; if (acc !== 1000) begin fails++; $display("FAIL sweep_timeout got=%0d exp=1000", acc); end
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL sweep_lost got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req_valid = 4'b0011; rsp_ready = 1'b0;
    set_lane(0, 16'h1234, 16'h0002);
    set_lane(1, 16'h0055, 16'h0003);
    @(negedge clk);
    @(negedge clk);
    tests++; if (inflight !== 2'd2) begin fails++; $display("FAIL mid_full got=%0d exp=2", inflight); end
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || inflight !== 2'd0) begin fails++; $display("FAIL mid_cleared got=v%b n%0d exp=v0 n0", rsp_valid, inflight); end
    tests++; if (rsp_p !== 32'h0 || mul_a !== 16'h0) begin fails++; $display("FAIL mid_data got=p%h a%h exp=0/0", rsp_p, mul_a); end
    // ptr was 2 before reset; requester 0 must now outrank requester 3.
    req_valid = 4'b1001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d] got=%b exp=0", c, rsp_valid); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_signed();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
